// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage initiator for LB/LBU/LH/LHU/LW/SB/SH/SW.
//
// Drives a word-wide data memory port. The port has no byte strobes: reads are
// combinational and writes land on posedge when mem_we is high. Sub-word stores
// are therefore done as read-modify-write.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   req_valid/ready   request handshake from the pipeline (ready only in IDLE)
//   req_we            1 = store, 0 = load
//   req_size          00 byte, 01 half, 10 word, 11 reserved (error)
//   req_signed        loads: 1 = sign-extend, 0 = zero-extend
//   req_addr          byte address
//   req_wdata         store data, right-justified
//   resp_valid        one-cycle completion pulse
//   resp_err          qualifies resp_valid: misaligned, reserved size, mem error
//   resp_rdata        extended load data, 0 for stores and errors
//   busy              unit is not IDLE; pipeline stalls on it
//   mem_addr          registered word address
//   mem_we            registered write enable, one cycle per store
//   mem_wdata         registered full write word
//   mem_rdata         combinational read data for mem_addr
//   mem_err           memory error for the current access
module mem_access_unit #(
    parameter int unsigned ADDR_W        = 32,
    parameter bit          MISALIGN_TRAP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_err
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StResp
    } state_e;

    state_e state_q, state_d;

    // Latched request
    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    // Registered outputs
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    logic       accept;
    logic       misaligned;
    logic       req_err;
    logic [1:0] lane_in;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign accept = req_valid && req_ready;

    always_comb begin
        misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                     ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
        req_err    = (req_size == 2'b11) || (MISALIGN_TRAP && misaligned);
        // Force natural alignment; only matters when misalignment does not trap.
        unique case (req_size)
            2'b01:   lane_in = {req_addr[1], 1'b0};
            2'b10:   lane_in = 2'b00;
            default: lane_in = req_addr[1:0];
        endcase
    end

    // Load extraction and sub-word merge both work on the live read word.
    always_comb begin
        sel_byte = mem_rdata[{lane_q, 3'b000} +: 8];
        sel_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (size_q)
            2'b00:   load_data = {{24{sgn_q & sel_byte[7]}}, sel_byte};
            2'b01:   load_data = {{16{sgn_q & sel_half[15]}}, sel_half};
            default: load_data = mem_rdata;
        endcase

        merged = mem_rdata;
        if (size_q == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                    if (req_err) begin
                        state_d    = StResp;
                        resp_err_d = 1'b1;
                    end else if (req_we && (req_size == 2'b10)) begin
                        state_d     = StWrite;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = req_wdata;
                    end else begin
                        // Loads and sub-word stores both read first.
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (mem_err) begin
                    state_d    = StResp;
                    resp_err_d = 1'b1;
                end else if (!we_q) begin
                    state_d      = StResp;
                    resp_rdata_d = load_data;
                end else begin
                    state_d     = StWrite;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged;
                end
            end
            StWrite: begin
                state_d    = StResp;
                resp_err_d = mem_err;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            sgn_q        <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 32'h0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_size;
                sgn_q   <= req_signed;
                lane_q  <= lane_in;
                wdata_q <= req_wdata[15:0];
            end
        end
    end

    // Gating with reset keeps req_ready low while reset is held.
    assign req_ready  = (state_q == StIdle) && reset;
    assign busy       = (state_q != StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver pushes expected responses,
// a negedge monitor pops and compares on every resp_valid.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, busy, mem_we, mem_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W       (32),
        .MISALIGN_TRAP(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_err  (resp_err),
        .resp_rdata(resp_rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err)
    );

    // Memory model: combinational read, posedge write, plus a preload port.
    logic [31:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;

    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
        else if (pre_we) mem[pre_idx] <= pre_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    int we_count = 0;
    logic [31:0] last_wdata, last_waddr;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
        int          we_base;
        int          nwr;
        logic [31:0] wdata;
        logic [31:0] waddr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (reset) begin
            if (mem_we) begin
                we_count++;
                last_wdata = mem_wdata;
                last_waddr = mem_addr;
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)",
                             cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_err", {31'b0, resp_err}, {31'b0, mon_e.err});
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                    chk("latency", cyc - mon_e.acc, mon_e.lat);
                    chk("mem_we_count", we_count - mon_e.we_base, mon_e.nwr);
                    if (mon_e.nwr > 0) begin
                        chk("mem_wdata", last_wdata, mon_e.wdata);
                        chk("mem_waddr", last_waddr, mon_e.waddr);
                    end
                end
            end
        end
    end

    task automatic load(input logic [9:0] idx, input logic [31:0] data);
        pre_idx  = idx;
        pre_data = data;
        pre_we   = 1'b1;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Presents a request and leaves req_valid high; returns the accept cycle.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic err, input logic [31:0] rdata, input int lat,
                         input int nwr, input logic [31:0] ewdata, output int acc);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (!req_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 (cycle %0d)", cyc);
        end else begin
            e.err     = err;
            e.rdata   = rdata;
            e.lat     = lat;
            e.acc     = cyc;
            e.we_base = we_count;
            e.nwr     = nwr;
            e.wdata   = ewdata;
            e.waddr   = {addr[31:2], 2'b00};
            sb.push_back(e);
            acc = cyc;
        end
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            n_checks++;
            $display("FAIL resp_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic err, input logic [31:0] rdata, input int lat,
                       input int nwr, input logic [31:0] ewdata);
        int acc;
        issue(we, size, sgn, addr, wdata, err, rdata, lat, nwr, ewdata, acc);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int acc1, acc2, wc;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_err    = 1'b0;

        load(10'd64, 32'h8899AABB);   // 0x100
        load(10'd128, 32'h11223344);  // 0x200

        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);

        // Loads
        run(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h8899AABB, 2, 0, 32'h0);
        run(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, 32'hFFFFFF88, 2, 0, 32'h0);
        run(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b0, 32'h00000088, 2, 0, 32'h0);
        run(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 1'b0, 32'hFFFFAABB, 2, 0, 32'h0);
        run(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b0, 32'h00008899, 2, 0, 32'h0);
        run(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1'b0, 32'hFFFFFFAA, 2, 0, 32'h0);

        // Stores: RMW byte, RMW half, full word
        run(1'b1, 2'b00, 1'b0, 32'h201, 32'h123456A5, 1'b0, 32'h0, 3, 1, 32'h1122A544);
        run(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, 32'h1122A544, 2, 0, 32'h0);
        run(1'b1, 2'b01, 1'b0, 32'h202, 32'h5555BEEF, 1'b0, 32'h0, 3, 1, 32'hBEEFA544);
        run(1'b1, 2'b10, 1'b0, 32'h204, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1, 32'hDEADBEEF);
        run(1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 1'b0, 32'hDEADBEEF, 2, 0, 32'h0);

        // Request-side errors
        run(1'b1, 2'b10, 1'b0, 32'h102, 32'hCAFEF00D, 1'b1, 32'h0, 1, 0, 32'h0);
        run(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0);
        run(1'b0, 2'b01, 1'b1, 32'h101, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0);

        // mem_err during READ: load, then sub-word store (no write allowed)
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 32'h0, 2, 0, 32'h0, acc1);
        @(negedge clk);
        req_valid = 1'b0;
        mem_err   = 1'b1;
        @(negedge clk);
        mem_err   = 1'b0;
        drain();
        issue(1'b1, 2'b00, 1'b0, 32'h200, 32'h77, 1'b1, 32'h0, 2, 0, 32'h0, acc1);
        @(negedge clk);
        req_valid = 1'b0;
        mem_err   = 1'b1;
        @(negedge clk);
        mem_err   = 1'b0;
        drain();
        chk("err_store_mem", mem[128], 32'hBEEFA544);

        // Reset during the READ of an SH
        issue(1'b1, 2'b01, 1'b0, 32'h200, 32'h7777, 1'b0, 32'h0, 3, 1, 32'h0, acc1);
        @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2;
        reset     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'h0);
        sb.delete();
        wc = we_count;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_rst_no_write", we_count - wc, 32'd0);
        chk("post_rst_mem", mem[128], 32'hBEEFA544);
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

        // Back-to-back LWs with req_valid held high
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 32'h8899AABB, 2, 0, 32'h0, acc1);
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, 32'hBEEFA544, 2, 0, 32'h0, acc2);
        chk("b2b_accept_gap", acc2 - acc1, 32'd3);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage initiator that drives the data memory port on behalf of the pipeline for loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW).
- The memory port is word-wide with no byte strobes: combinational read, write on posedge when write-enabled.
- Sub-word stores are therefore done as read-modify-write.
- Handles alignment checks, byte-lane extraction and merge, sign/zero extension, and the busy/stall handshake to the pipeline.

Parameters:
- ADDR_W, 32, width of req_addr and mem_addr.
- MISALIGN_TRAP, 1:
  - 1: misaligned access returns resp_err and performs no memory access.
  - 0: low address bits are forced to the natural alignment and the access proceeds.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline presents a request.
- req_ready  out  1  unit can accept (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (error).
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: misaligned, reserved size, or memory error.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- busy  out  1  state != IDLE; pipeline stalls on it.
- mem_addr  out  ADDR_W  registered word address {addr[ADDR_W-1:2], 2'b00}.
- mem_we  out  1  write enable, high for exactly one cycle per store.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  combinational read data for mem_addr.
- mem_err  in  1  memory error for the current access.

Behaviour:
- Reset (reset low, async):
  - State goes to IDLE.
  - All outputs 0, except req_ready = 1 once reset is high.
  - mem_we drops immediately.
  - Any in-flight access is abandoned: no later write, no response.
- States: IDLE, READ, WRITE, RESP.
- IDLE, on req_valid & req_ready, latch the request, then:
  - Error (misaligned with MISALIGN_TRAP = 1, or req_size = 11) -> RESP with resp_err = 1.
  - Load -> READ.
  - Word store -> WRITE.
  - Byte/half store -> READ.
- Alignment: half requires addr[0] = 0; word requires addr[1:0] = 0; bytes are always aligned.
- READ:
  - mem_addr is valid and mem_we = 0.
  - Capture mem_rdata at the end of the cycle.
  - mem_err = 1 -> RESP with error.
  - Otherwise a load goes to RESP; a sub-word store goes to WRITE.
- WRITE:
  - mem_we = 1 for one cycle.
  - mem_wdata is either req_wdata (word store) or the captured word with the target lane(s) replaced.
  - Merge is little-endian: byte lane = addr[1:0]*8; half lane = addr[1]*16.
  - mem_err = 1 -> RESP with error, otherwise RESP clean.
- RESP:
  - resp_valid = 1 for one cycle, then IDLE.
  - req_ready stays 0, so there is no back-to-back accept in RESP.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Extend to 32 bits per req_signed.
- Latency from accept cycle T (resp_valid asserted in cycle):
  - Error: T+1.
  - Load: T+2.
  - Word store: T+2.
  - Sub-word store: T+3.
- Memory writes:
  - Exactly one mem_we pulse per successful store.
  - No mem_we pulse for loads or errors.
  - No mem_we after an error is detected in READ.
- Other rules:
  - req_* inputs are ignored outside IDLE; latched values govern the whole access.
  - mem_addr, mem_wdata and mem_we are registered (glitch-free).
  - mem_addr holds its last value in IDLE.

Test Plan:
- Word load: mem[0x100] = 0x8899AABB; LW 0x100 -> resp_valid at T+2, resp_rdata = 0x8899AABB, resp_err = 0, no mem_we.
- Sub-word loads from mem[0x100] = 0x8899AABB:
  - LB 0x103, signed -> 0xFFFFFF88.
  - LBU 0x103 -> 0x00000088.
  - LH 0x100, signed -> 0xFFFFAABB.
- Byte store RMW: mem[0x200] = 0x11223344; SB 0x201, wdata 0xA5 -> READ at T+1, single mem_we at T+2 with mem_wdata = 0x1122A544, resp at T+3.
- Error paths:
  - SW 0x102 (MISALIGN_TRAP = 1) -> resp_err at T+1, mem_we never asserted, resp_rdata = 0.
  - req_size = 11 -> same response.
  - LW with mem_err = 1 in READ -> resp_err = 1 at T+2.
- Reset and back-to-back:
  - Assert reset during READ of an SH -> outputs 0 immediately, no mem_we afterwards, no resp_valid.
  - After reset release, two back-to-back LWs with req_valid held high -> second is accepted only after the first's RESP.
  - busy stays high across both accesses except the single IDLE accept cycle.
